ut_gen: RTL and testbench
=========================

UT_GEN -- requirements
Module: ut_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits (allowed 4..32).
REQ-002 SHALL have parameter NREG, default 4, number of general registers (power of two, allowed 2..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ce  input  1  clock enable; when low, all state is held.
REQ-006 SHALL have port op  input  4  opcode.
REQ-007 SHALL have port op_valid  input  1  opcode present.
REQ-008 SHALL have port op_ready  output  1  unit can accept an opcode.
REQ-009 SHALL have port src_sel  input  $clog2(NREG)  source register index.
REQ-010 SHALL have port dst_sel  input  $clog2(NREG)  destination register index.
REQ-011 SHALL have port data_in  input  WIDTH  immediate operand.
REQ-012 SHALL have port data_out  output  WIDTH  accumulator value.
REQ-013 SHALL have port carry  output  1  carry flag.
REQ-014 SHALL have port zero  output  1  high when accumulator == 0 (combinational from acc).
REQ-015 SHALL have port busy  output  1  multi-cycle operation in progress.

Function
REQ-016 SHALL accept an op on a rising edge where ce && op_valid && op_ready; otherwise op is ignored.
REQ-017 SHALL decode opcodes: 0 NOP, 1 LDA acc<=data_in, 2 LDR r[dst]<=data_in, 3 ADD, 4 ADC (adds carry), 5 SUB, 6 AND, 7 OR, 8 XOR, 9 SHL, 10 SHR, 11 STA r[dst]<=acc, 12 CLC carry<=0, 13 SEC carry<=1, 14 MUL, 15 NOP.
REQ-018 SHALL make ADD/ADC/SUB/AND/OR/XOR operate on acc and r[src], result into acc, modulo 2^WIDTH.
REQ-019 SHALL set carry on ADD/ADC to bit WIDTH of the WIDTH+1-bit sum; on SUB to 1 iff borrow (acc < r[src]).
REQ-020 SHALL make SHL/SHR rotate acc through carry (SHL: carry<=acc[MSB]; SHR: carry<=acc[0]); logic ops leave carry unchanged.
REQ-021 SHALL make every single-cycle op visible on data_out/carry/zero on the first edge after acceptance; op_ready stays 1.
REQ-022 SHALL implement MUL as WIDTH-iteration shift-add: product acc*r[src]; low half into acc, high half into r[dst]; carry<=0.
REQ-023 SHALL use FSM states IDLE and MUL: IDLE->MUL on MUL acceptance; MUL->IDLE when the iteration counter reaches WIDTH-1.
REQ-024 SHALL drive busy=1 and op_ready=0 exactly during MUL state; MUL accepted at edge t -> result and op_ready=1 after edge t+WIDTH.
REQ-025 SHALL latch src/dst operands at MUL acceptance; input changes during MUL have no effect.
REQ-026 SHALL, when ce is low, freeze the FSM, iteration counter, registers and flags; MUL completion is delayed by the number of ce-low cycles.
REQ-027 SHALL, when src_sel == dst_sel on MUL, read the original r[src] and write the high half into that register.

Reset
REQ-028 SHALL, on rst_n low, immediately clear acc, all r[], carry, counter; FSM to IDLE; outputs: data_out=0, carry=0, zero=1, busy=0, op_ready=1.
REQ-029 SHALL abort any MUL in progress on reset with no partial result retained.

Configuration
REQ-030 SHALL compile MUL support only when macro UT_GEN_MUL_EN is defined; without it opcode 14 SHALL behave as NOP, the MUL state and counter SHALL be absent, busy tied 0, op_ready tied 1.

Structure
REQ-031 SHALL place opcode constants, FSM state type and ALU result struct in shared package ut_gen_pkg.
REQ-032 SHALL split the combinational ALU (ops 3-10) into sub-module ut_gen_alu; sequencing and register bank stay in ut_gen.

Verification (WIDTH=8, NREG=4)
REQ-033 SHALL check reset: rst_n low mid-run -> data_out=0x00, carry=0, zero=1, op_ready=1 without a clock edge.
REQ-034 SHALL check LDA 0xF0, LDR r1=0x20, ADD src=1 -> data_out=0x10, carry=1, zero=0.
REQ-035 SHALL check LDA 0x05, LDR r2=0x07, SUB src=2 -> data_out=0xFE, carry=1; then SHR -> data_out=0xFF, carry=0.
REQ-036 SHALL check LDA 0xFF, LDR r1=0xFF, MUL src=1 dst=3 -> op_ready low 8 cycles, then data_out=0x01, r3=0xFE, carry=0; op_valid pulses during busy ignored.
REQ-037 SHALL check ce low for 3 cycles during MUL -> completion at 11 cycles after acceptance, same result; rst_n low at MUL iteration 3 -> all cleared, FSM IDLE.
REQ-038 SHALL check with UT_GEN_MUL_EN undefined: MUL -> acc, registers and flags unchanged, op_ready stays 1.

Source files
------------

// File: rtl/ut_gen_pkg.sv
// ut_gen_pkg -- shared definitions for the ut_gen accumulator unit.
//   op_t      : 4-bit opcode encoding
//   state_t   : sequencer states (MUL state is only used when UT_GEN_MUL_EN is defined)
//   alu_res_t : ALU side-band result (op recognised + carry out)
package ut_gen_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LDA  = 4'd1,
        OP_LDR  = 4'd2,
        OP_ADD  = 4'd3,
        OP_ADC  = 4'd4,
        OP_SUB  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_XOR  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_STA  = 4'd11,
        OP_CLC  = 4'd12,
        OP_SEC  = 4'd13,
        OP_MUL  = 4'd14,
        OP_NOP2 = 4'd15
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    // hit: opcode is one the ALU handles (3..10); acc/carry take y/carry when set
    typedef struct packed {
        logic hit;
        logic carry;
    } alu_res_t;

endpackage

// File: rtl/ut_gen_alu.sv
// ut_gen_alu -- combinational ALU for opcodes ADD..SHR.
//   op_i    : opcode
//   a_i     : accumulator operand
//   b_i     : register operand r[src]
//   carry_i : current carry flag
//   y_o     : result (valid when res_o.hit)
//   res_o   : {hit, carry out}; logic ops pass carry_i through
module ut_gen_alu
    import ut_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] y_o,
    output alu_res_t         res_o
);

    logic [WIDTH:0] sum_add;
    logic [WIDTH:0] sum_adc;

    assign sum_add = {1'b0, a_i} + {1'b0, b_i};
    assign sum_adc = sum_add + {{WIDTH{1'b0}}, carry_i};

    always_comb begin
        y_o         = '0;
        res_o.hit   = 1'b0;
        res_o.carry = carry_i;
        case (op_t'(op_i))
            OP_ADD: begin
                y_o         = sum_add[WIDTH-1:0];
                res_o.hit   = 1'b1;
                res_o.carry = sum_add[WIDTH];
            end
            OP_ADC: begin
                y_o         = sum_adc[WIDTH-1:0];
                res_o.hit   = 1'b1;
                res_o.carry = sum_adc[WIDTH];
            end
            OP_SUB: begin
                y_o         = a_i - b_i;
                res_o.hit   = 1'b1;
                res_o.carry = (a_i < b_i);
            end
            OP_AND: begin
                y_o       = a_i & b_i;
                res_o.hit = 1'b1;
            end
            OP_OR: begin
                y_o       = a_i | b_i;
                res_o.hit = 1'b1;
            end
            OP_XOR: begin
                y_o       = a_i ^ b_i;
                res_o.hit = 1'b1;
            end
            // shifts rotate through carry
            OP_SHL: begin
                y_o         = {a_i[WIDTH-2:0], carry_i};
                res_o.hit   = 1'b1;
                res_o.carry = a_i[WIDTH-1];
            end
            OP_SHR: begin
                y_o         = {carry_i, a_i[WIDTH-1:1]};
                res_o.hit   = 1'b1;
                res_o.carry = a_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ut_gen.sv
// ut_gen -- accumulator unit with register bank and optional shift-add multiplier.
// Optional feature macro: UT_GEN_MUL_EN (multiply opcode; without it opcode 14 is a NOP).
//   clk, rst_n          : clock, asynchronous active-low reset
//   ce                  : clock enable, holds all state when low
//   op, op_valid        : opcode and its valid strobe
//   op_ready            : unit can accept an opcode (low only while multiplying)
//   src_sel, dst_sel    : register bank indices
//   data_in             : immediate operand
//   data_out            : accumulator
//   carry, zero         : flags (zero derived from accumulator)
//   busy                : multiply in progress
module ut_gen
    import ut_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic [3:0]              op,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [$clog2(NREG)-1:0] src_sel,
    input  logic [$clog2(NREG)-1:0] dst_sel,
    input  logic [WIDTH-1:0]        data_in,
    output logic [WIDTH-1:0]        data_out,
    output logic                    carry,
    output logic                    zero,
    output logic                    busy
);

    localparam int unsigned SW = $clog2(NREG);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];

    logic [WIDTH-1:0] alu_y;
    alu_res_t         alu_res;
    logic             accept;

`ifdef UT_GEN_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [SW-1:0]    dst_q, dst_d;
    logic [WIDTH:0]   step_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // One shift-add iteration: {hi,lo} starts as {0, multiplier}; conditionally add
    // the multiplicand to hi, then shift {sum, lo} right by one.
    assign step_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign step_hi  = step_sum[WIDTH:1];
    assign step_lo  = {step_sum[0], lo_q[WIDTH-1:1]};

    assign busy     = (state_q == MUL);
    assign op_ready = (state_q == IDLE);
`else
    assign busy     = 1'b0;
    assign op_ready = 1'b1;
`endif

    assign accept   = ce & op_valid & op_ready;
    assign data_out = acc_q;
    assign carry    = carry_q;
    assign zero     = (acc_q == '0);

    ut_gen_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op_i    (op),
        .a_i     (acc_q),
        .b_i     (regs_q[src_sel]),
        .carry_i (carry_q),
        .y_o     (alu_y),
        .res_o   (alu_res)
    );

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        regs_d  = regs_q;
`ifdef UT_GEN_MUL_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        dst_d   = dst_q;
`endif
        if (accept) begin
            case (op_t'(op))
                OP_LDA: acc_d = data_in;
                OP_LDR: regs_d[dst_sel] = data_in;
                OP_STA: regs_d[dst_sel] = acc_q;
                OP_CLC: carry_d = 1'b0;
                OP_SEC: carry_d = 1'b1;
`ifdef UT_GEN_MUL_EN
                // operands captured here so r[src] is read before any write-back
                OP_MUL: begin
                    state_d = MUL;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = regs_q[src_sel];
                    mcand_d = acc_q;
                    dst_d   = dst_sel;
                end
`endif
                default: begin
                    if (alu_res.hit) begin
                        acc_d   = alu_y;
                        carry_d = alu_res.carry;
                    end
                end
            endcase
        end
`ifdef UT_GEN_MUL_EN
        if (ce && (state_q == MUL)) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d        = IDLE;
                cnt_d          = '0;
                acc_d          = step_lo;
                regs_d[dst_q]  = step_hi;
                carry_d        = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            regs_q  <= '{default: '0};
`ifdef UT_GEN_MUL_EN
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            dst_q   <= '0;
`endif
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            regs_q  <= regs_d;
`ifdef UT_GEN_MUL_EN
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            dst_q   <= dst_d;
`endif
        end
    end

endmodule

// File: tb/tb_ut_gen.sv
// tb_ut_gen -- directed self-checking bench for ut_gen (WIDTH=8, NREG=4).
// Multiply scenarios are compiled when UT_GEN_MUL_EN is defined; otherwise
// opcode 14 is checked to behave as a NOP.
module tb_ut_gen;
    import ut_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ce;
    logic [3:0] op;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] src_sel;
    logic [1:0] dst_sel;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       carry;
    logic       zero;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    ut_gen #(
        .WIDTH (8),
        .NREG  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .op       (op),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .src_sel  (src_sel),
        .dst_sel  (dst_sel),
        .data_in  (data_in),
        .data_out (data_out),
        .carry    (carry),
        .zero     (zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Present one opcode for exactly one edge; returns 1 time unit after that edge.
    task automatic issue(input logic [3:0] o, input logic [1:0] s, input logic [1:0] d,
                         input logic [7:0] dat);
        op = o; src_sel = s; dst_sel = d; data_in = dat; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    // Observe r[r] through the accumulator (clobbers acc and carry).
    task automatic read_reg(input logic [1:0] r, output logic [7:0] v);
        issue(OP_LDA, 2'd0, 2'd0, 8'h00);
        issue(OP_ADD, r, 2'd0, 8'h00);
        v = data_out;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ce = 1'b1; op = OP_NOP; op_valid = 1'b0;
        src_sel = '0; dst_sel = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL por_data: got %h expected 00", data_out); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL por_zero: got %b expected 1", zero); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL por_busy: got %b expected 0", busy); end
        issue(OP_LDA, 2'd0, 2'd0, 8'h5A);
        issue(OP_SEC, 2'd0, 2'd0, 8'h00);
        n_checks++; if (data_out !== 8'h5A) begin n_fail++; $display("FAIL pre_rst_data: got %h expected 5a", data_out); end
        n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL pre_rst_carry: got %b expected 1", carry); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h expected 00", data_out); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL rst_carry: got %b expected 0", carry); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL rst_zero: got %b expected 1", zero); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", op_ready); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_add;
        issue(OP_LDA, 2'd0, 2'd0, 8'hF0);
        issue(OP_LDR, 2'd0, 2'd1, 8'h20);
        issue(OP_ADD, 2'd1, 2'd0, 8'h00);
        n_checks++; if (data_out !== 8'h10) begin n_fail++; $display("FAIL add_data: got %h expected 10", data_out); end
        n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL add_carry: got %b expected 1", carry); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b expected 0", zero); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL add_ready: got %b expected 1", op_ready); end
    endtask

    task automatic test_sub_shr;
        issue(OP_LDA, 2'd0, 2'd0, 8'h05);
        issue(OP_LDR, 2'd0, 2'd2, 8'h07);
        issue(OP_SUB, 2'd2, 2'd0, 8'h00);
        n_checks++; if (data_out !== 8'hFE) begin n_fail++; $display("FAIL sub_data: got %h expected fe", data_out); end
        n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL sub_borrow: got %b expected 1", carry); end
        issue(OP_SHR, 2'd0, 2'd0, 8'h00);
        n_checks++; if (data_out !== 8'hFF) begin n_fail++; $display("FAIL shr_data: got %h expected ff", data_out); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL shr_carry: got %b expected 0", carry); end
    endtask

    task automatic test_logic;
        logic [7:0] v;
        issue(OP_LDA, 2'd0, 2'd0, 8'hCC);
        issue(OP_LDR, 2'd0, 2'd0, 8'hAA);
        issue(OP_SEC, 2'd0, 2'd0, 8'h00);
        issue(OP_AND, 2'd0, 2'd0, 8'h00);
        n_checks++; if (data_out !== 8'h88) begin n_fail++; $display("FAIL and_data: got %h expected 88", data_out); end
        n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL and_carry_kept: got %b expected 1", carry); end
        issue(OP_OR, 2'd0, 2'd0, 8'h00);
        n_checks++; if (data_out !== 8'hAA) begin n_fail++; $display("FAIL or_data: got %h expected aa", data_out); end
        issue(OP_XOR, 2'd0, 2'd0, 8'h00);
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL xor_data: got %h expected 00", data_out); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL xor_zero: got %b expected 1", zero); end
        issue(OP_ADC, 2'd0, 2'd0, 8'h00);
        n_checks++; if (data_out !== 8'hAB) begin n_fail++; $display("FAIL adc_data: got %h expected ab", data_out); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL adc_carry: got %b expected 0", carry); end
        issue(OP_SHL, 2'd0, 2'd0, 8'h00);
        n_checks++; if (data_out !== 8'h56) begin n_fail++; $display("FAIL shl_data: got %h expected 56", data_out); end
        n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL shl_carry: got %b expected 1", carry); end
        issue(OP_STA, 2'd0, 2'd3, 8'h00);
        issue(OP_CLC, 2'd0, 2'd0, 8'h00);
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL clc_carry: got %b expected 0", carry); end
        read_reg(2'd3, v);
        n_checks++; if (v !== 8'h56) begin n_fail++; $display("FAIL sta_r3: got %h expected 56", v); end
    endtask

    task automatic test_ce_hold;
        issue(OP_LDA, 2'd0, 2'd0, 8'h33);
        ce = 1'b0;
        issue(OP_LDA, 2'd0, 2'd0, 8'h44);
        ce = 1'b1;
        n_checks++; if (data_out !== 8'h33) begin n_fail++; $display("FAIL ce_hold_data: got %h expected 33", data_out); end
    endtask

`ifdef UT_GEN_MUL_EN
    task automatic test_mul;
        logic [7:0] v;
        int low_cnt;
        issue(OP_LDA, 2'd0, 2'd0, 8'hFF);
        issue(OP_LDR, 2'd0, 2'd1, 8'hFF);
        op = OP_MUL; src_sel = 2'd1; dst_sel = 2'd3; op_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mul_busy: got %b expected 1", busy); end
        // keep offering a conflicting op with different selects while busy
        op = OP_LDA; data_in = 8'h55; src_sel = 2'd0; dst_sel = 2'd0;
        low_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (op_ready) break;
            low_cnt++;
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        n_checks++; if (low_cnt !== 8) begin n_fail++; $display("FAIL mul_ready_low_cycles: got %0d expected 8", low_cnt); end
        n_checks++; if (data_out !== 8'h01) begin n_fail++; $display("FAIL mul_lo: got %h expected 01", data_out); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL mul_carry: got %b expected 0", carry); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_end: got %b expected 0", busy); end
        read_reg(2'd3, v);
        n_checks++; if (v !== 8'hFE) begin n_fail++; $display("FAIL mul_hi_r3: got %h expected fe", v); end
        read_reg(2'd1, v);
        n_checks++; if (v !== 8'hFF) begin n_fail++; $display("FAIL mul_r1_kept: got %h expected ff", v); end
    endtask

    task automatic test_mul_ce;
        logic [7:0] v;
        int done;
        issue(OP_LDA, 2'd0, 2'd0, 8'h03);
        issue(OP_LDR, 2'd0, 2'd2, 8'h05);
        issue(OP_MUL, 2'd2, 2'd2, 8'h00);
        done = 0;
        for (int k = 1; k <= 20; k++) begin
            ce = !(k >= 3 && k <= 5);
            @(posedge clk); #1;
            if (op_ready) begin done = k; break; end
        end
        ce = 1'b1;
        n_checks++; if (done !== 11) begin n_fail++; $display("FAIL mul_ce_latency: got %0d expected 11", done); end
        n_checks++; if (data_out !== 8'h0F) begin n_fail++; $display("FAIL mul_ce_lo: got %h expected 0f", data_out); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL mul_ce_carry: got %b expected 0", carry); end
        read_reg(2'd2, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL mul_same_reg_hi: got %h expected 00", v); end
    endtask

    task automatic test_mul_reset;
        logic [7:0] v;
        issue(OP_LDA, 2'd0, 2'd0, 8'h0F);
        issue(OP_LDR, 2'd0, 2'd1, 8'h03);
        issue(OP_SEC, 2'd0, 2'd0, 8'h00);
        issue(OP_MUL, 2'd1, 2'd2, 8'h00);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mulrst_data: got %h expected 00", data_out); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL mulrst_carry: got %b expected 0", carry); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL mulrst_zero: got %b expected 1", zero); end
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL mulrst_ready: got %b expected 1", op_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mulrst_busy: got %b expected 0", busy); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mulrst_no_late_result: got %h expected 00", data_out); end
        read_reg(2'd2, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL mulrst_r2: got %h expected 00", v); end
        read_reg(2'd1, v);
        n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL mulrst_r1: got %h expected 00", v); end
    endtask
`else
    task automatic test_mul_disabled;
        logic [7:0] v;
        issue(OP_LDA, 2'd0, 2'd0, 8'h12);
        issue(OP_LDR, 2'd0, 2'd1, 8'h03);
        issue(OP_SEC, 2'd0, 2'd0, 8'h00);
        issue(OP_MUL, 2'd1, 2'd1, 8'h00);
        n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL nomul_ready: got %b expected 1", op_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nomul_busy: got %b expected 0", busy); end
        n_checks++; if (data_out !== 8'h12) begin n_fail++; $display("FAIL nomul_acc: got %h expected 12", data_out); end
        n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL nomul_carry: got %b expected 1", carry); end
        read_reg(2'd1, v);
        n_checks++; if (v !== 8'h03) begin n_fail++; $display("FAIL nomul_r1: got %h expected 03", v); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub_shr();
        test_logic();
        test_ce_hold();
`ifdef UT_GEN_MUL_EN
        test_mul();
        test_mul_ce();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
